// File: rtl/aurora_rx_nfc_buffer.sv
// Aurora RX buffer: FIFO of {TLAST, TDATA} drained to the router under Q_BP,
// with NFC XOFF/XON requests driven from level watermarks.
module aurora_rx_nfc_buffer #(
  parameter int unsigned DW            = 64,
  parameter int unsigned AW            = 9,
  parameter int unsigned HI_WM         = (2**AW) - 32,
  parameter int unsigned LO_WM         = (2**AW) / 4,
  parameter int unsigned REFRESH       = 256,
  parameter logic [15:0] NFC_XOFF_CODE = 16'h00FF,
  parameter logic [15:0] NFC_XON_CODE  = 16'h0000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] RX_TDATA,
  input  logic          RX_TVALID,
  input  logic          RX_TLAST,
  output logic [DW-1:0] Q,
  output logic          Q_VALID,
  output logic          Q_LAST,
  input  logic          Q_BP,
  output logic          NFC_TVALID,
  output logic [15:0]   NFC_TDATA,
  input  logic          NFC_TREADY,
  output logic [AW:0]   LEVEL,
  output logic          XOFF_STATE,
  output logic          OVERFLOW
);

  localparam int unsigned DEPTH        = 2**AW;
  localparam logic [AW:0] FULL_LVL     = (AW+1)'(DEPTH);
  localparam logic [AW:0] HI_LVL       = (AW+1)'(HI_WM);
  localparam logic [AW:0] LO_LVL       = (AW+1)'(LO_WM);
  localparam int unsigned CW           = $clog2(REFRESH) + 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH - 1);

  typedef enum logic [1:0] {
    XON_IDLE,
    SEND_XOFF,
    XOFF_HOLD,
    SEND_XON
  } nfc_state_t;

  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          xfer;
  logic          wr_en;
  logic          rd_en;

  nfc_state_t    state;
  nfc_state_t    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign full  = (LEVEL == FULL_LVL);
  assign empty = (LEVEL == '0);
  assign xfer  = Q_VALID && !Q_BP;
  assign wr_en = RX_TVALID && !full;
  assign rd_en = (!Q_VALID || xfer) && !empty;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= {RX_TLAST, RX_TDATA};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      LEVEL    <= '0;
      Q        <= '0;
      Q_LAST   <= 1'b0;
      Q_VALID  <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // A word leaves RAM only into the output register, so LEVEL excludes it
      if (rd_en) begin
        rd_ptr          <= rd_ptr + AW'(1);
        {Q_LAST, Q}     <= mem[rd_ptr];
        Q_VALID         <= 1'b1;
      end else if (xfer) begin
        Q_VALID <= 1'b0;
      end
      case ({wr_en, rd_en})
        2'b10:   LEVEL <= LEVEL + (AW+1)'(1);
        2'b01:   LEVEL <= LEVEL - (AW+1)'(1);
        default: LEVEL <= LEVEL;
      endcase
      if (RX_TVALID && full) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= XON_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    NFC_TVALID = 1'b0;
    NFC_TDATA  = NFC_XON_CODE;
    XOFF_STATE = 1'b0;
    case (state)
      XON_IDLE: begin
        if (LEVEL >= HI_LVL) begin
          state_next = SEND_XOFF;
        end
      end
      SEND_XOFF: begin
        NFC_TVALID = 1'b1;
        NFC_TDATA  = NFC_XOFF_CODE;
        XOFF_STATE = 1'b1;
        if (NFC_TREADY) begin
          state_next = XOFF_HOLD;
          cnt_next   = '0;
        end
      end
      XOFF_HOLD: begin
        XOFF_STATE = 1'b1;
        cnt_next   = cnt + CW'(1);
        // Low watermark wins over a due refresh
        if (LEVEL <= LO_LVL) begin
          state_next = SEND_XON;
        end else if (cnt == REFRESH_LAST) begin
          state_next = SEND_XOFF;
        end
      end
      SEND_XON: begin
        NFC_TVALID = 1'b1;
        if (NFC_TREADY) begin
          state_next = XON_IDLE;
        end
      end
      default: state_next = XON_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aurora_rx_nfc_buffer.sv
// Bench for aurora_rx_nfc_buffer: queue-based reference for the data path,
// hand-derived cycle expectations for the NFC watermark/refresh behaviour.
module tb_aurora_rx_nfc_buffer;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_TDATA;
  logic          RX_TVALID;
  logic          RX_TLAST;
  logic [DW-1:0] Q;
  logic          Q_VALID;
  logic          Q_LAST;
  logic          Q_BP;
  logic          NFC_TVALID;
  logic [15:0]   NFC_TDATA;
  logic          NFC_TREADY;
  logic [AW:0]   LEVEL;
  logic          XOFF_STATE;
  logic          OVERFLOW;

  int npass  = 0;
  int ntotal = 0;

  logic [DW:0]   m_ram[$];
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_q     = '0;
  logic          m_last  = 1'b0;
  logic          m_ovf   = 1'b0;
  logic [AW:0]   m_lvl   = '0;

  aurora_rx_nfc_buffer #(
    .DW(DW), .AW(AW), .HI_WM(12), .LO_WM(4), .REFRESH(8),
    .NFC_XOFF_CODE(16'h00FF), .NFC_XON_CODE(16'h0000)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_TDATA(RX_TDATA), .RX_TVALID(RX_TVALID), .RX_TLAST(RX_TLAST),
    .Q(Q), .Q_VALID(Q_VALID), .Q_LAST(Q_LAST), .Q_BP(Q_BP),
    .NFC_TVALID(NFC_TVALID), .NFC_TDATA(NFC_TDATA), .NFC_TREADY(NFC_TREADY),
    .LEVEL(LEVEL), .XOFF_STATE(XOFF_STATE), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one cycle of inputs, advance one edge, and advance the reference.
  task automatic step(input logic rst, input logic v, input logic [DW-1:0] d,
                      input logic l, input logic bp, input logic rdy);
    logic [DW:0] w;
    bit xfer, load, can_wr;
    RST = rst; RX_TVALID = v; RX_TDATA = d; RX_TLAST = l; Q_BP = bp; NFC_TREADY = rdy;
    @(posedge CLK);
    if (rst) begin
      m_ram.delete();
      m_valid = 1'b0; m_q = '0; m_last = 1'b0; m_ovf = 1'b0;
    end else begin
      xfer   = m_valid && !bp;
      load   = (!m_valid || xfer) && (m_ram.size() > 0);
      can_wr = v && (m_ram.size() < DEPTH);
      if (v && m_ram.size() == DEPTH) m_ovf = 1'b1;
      if (load) begin
        w = m_ram.pop_front();
        m_q = w[DW-1:0]; m_last = w[DW]; m_valid = 1'b1;
      end else if (xfer) begin
        m_valid = 1'b0;
      end
      if (can_wr) m_ram.push_back({l, d});
    end
    m_lvl = (AW+1)'(m_ram.size());
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, i[0], {$urandom, $urandom}, 1'b1, 0, 0);
      ntotal++;
      if ({Q, Q_VALID, Q_LAST, NFC_TVALID, NFC_TDATA, LEVEL, XOFF_STATE, OVERFLOW} !==
          {64'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0})
        $display("FAIL reset_values cyc=%0d got q=%h v=%b l=%b nv=%b nd=%h lvl=%0d xs=%b ovf=%b required all zero",
                 i, Q, Q_VALID, Q_LAST, NFC_TVALID, NFC_TDATA, LEVEL, XOFF_STATE, OVERFLOW);
      else npass++;
    end
    step(0, 0, '0, 0, 0, 0);
    ntotal++;
    if ({LEVEL, Q_VALID} !== {5'd0, 1'b0})
      $display("FAIL reset_release got lvl=%0d v=%b required lvl=0 v=0", LEVEL, Q_VALID);
    else npass++;
  endtask

  task automatic test_passthrough();
    logic [DW-1:0] d[5];
    do_reset();
    for (int i = 0; i < 5; i++) d[i] = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      step(0, i < 5, (i < 5) ? d[i] : '0, i == 4, 0, 0);
      ntotal++;
      if ({Q_VALID, Q_LAST, Q, LEVEL, OVERFLOW} !== {m_valid, m_last, m_q, m_lvl, m_ovf})
        $display("FAIL passthrough_dp cyc=%0d got v=%b l=%b q=%h lvl=%0d ovf=%b required v=%b l=%b q=%h lvl=%0d ovf=%b",
                 i, Q_VALID, Q_LAST, Q, LEVEL, OVERFLOW, m_valid, m_last, m_q, m_lvl, m_ovf);
      else npass++;
      if (i == 0) begin
        ntotal++;
        if (Q_VALID !== 1'b0) $display("FAIL passthrough_early got v=%b required 0", Q_VALID);
        else npass++;
      end
      if (i >= 1 && i <= 5) begin
        ntotal++;
        if ({Q_VALID, Q_LAST, Q} !== {1'b1, i == 5, d[i-1]})
          $display("FAIL passthrough_word cyc=%0d got v=%b l=%b q=%h required v=1 l=%b q=%h",
                   i, Q_VALID, Q_LAST, Q, i == 5, d[i-1]);
        else npass++;
      end
    end
    ntotal++;
    if ({LEVEL, Q_VALID} !== {5'd0, 1'b0})
      $display("FAIL passthrough_empty got lvl=%0d v=%b required 0 0", LEVEL, Q_VALID);
    else npass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d[4];
    do_reset();
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      if (i < 4)      step(0, 1, d[i], i == 3, i != 0, 0);
      else if (i < 6) step(0, 0, '0, 0, 1, 0);
      else            step(0, 0, '0, 0, 0, 0);
      ntotal++;
      if ({Q_VALID, Q_LAST, Q, LEVEL, OVERFLOW} !== {m_valid, m_last, m_q, m_lvl, m_ovf})
        $display("FAIL backpressure_dp cyc=%0d got v=%b l=%b q=%h lvl=%0d ovf=%b required v=%b l=%b q=%h lvl=%0d ovf=%b",
                 i, Q_VALID, Q_LAST, Q, LEVEL, OVERFLOW, m_valid, m_last, m_q, m_lvl, m_ovf);
      else npass++;
      if (i >= 3 && i <= 5) begin
        ntotal++;
        if ({Q_VALID, Q, LEVEL} !== {1'b1, d[0], 5'd3})
          $display("FAIL backpressure_hold cyc=%0d got v=%b q=%h lvl=%0d required v=1 q=%h lvl=3",
                   i, Q_VALID, Q, LEVEL, d[0]);
        else npass++;
      end
      if (i >= 6 && i <= 8) begin
        ntotal++;
        if ({Q_VALID, Q_LAST, Q} !== {1'b1, i == 8, d[i-5]})
          $display("FAIL backpressure_release cyc=%0d got v=%b l=%b q=%h required v=1 l=%b q=%h",
                   i, Q_VALID, Q_LAST, Q, i == 8, d[i-5]);
        else npass++;
      end
    end
  endtask

  task automatic test_xoff_xon();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(0, 1, {$urandom, $urandom}, 0, 1, 0);
      ntotal++;
      if (NFC_TVALID !== 1'b0) $display("FAIL xoff_early cyc=%0d got nv=%b required 0", i, NFC_TVALID);
      else npass++;
    end
    ntotal++;
    if (LEVEL !== 5'd12) $display("FAIL xoff_level got lvl=%0d required 12", LEVEL);
    else npass++;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, 0, 1, 0);
      ntotal++;
      if ({NFC_TVALID, NFC_TDATA, XOFF_STATE} !== {1'b1, 16'h00FF, 1'b1})
        $display("FAIL xoff_request cyc=%0d got nv=%b nd=%h xs=%b required nv=1 nd=00ff xs=1",
                 i, NFC_TVALID, NFC_TDATA, XOFF_STATE);
      else npass++;
    end
    step(0, 0, '0, 0, 0, 1);
    ntotal++;
    if ({NFC_TVALID, XOFF_STATE, LEVEL} !== {1'b0, 1'b1, 5'd11})
      $display("FAIL xoff_accept got nv=%b xs=%b lvl=%0d required nv=0 xs=1 lvl=11", NFC_TVALID, XOFF_STATE, LEVEL);
    else npass++;
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, '0, 0, 0, 0);
      ntotal++;
      if ({NFC_TVALID, XOFF_STATE, Q_VALID, Q, LEVEL} !== {1'b0, 1'b1, m_valid, m_q, m_lvl})
        $display("FAIL xoff_hold k=%0d got nv=%b xs=%b v=%b q=%h lvl=%0d required nv=0 xs=1 v=%b q=%h lvl=%0d",
                 k, NFC_TVALID, XOFF_STATE, Q_VALID, Q, LEVEL, m_valid, m_q, m_lvl);
      else npass++;
    end
    ntotal++;
    if (LEVEL !== 5'd4) $display("FAIL xon_level got lvl=%0d required 4", LEVEL);
    else npass++;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, '0, 0, 1, 0);
      ntotal++;
      if ({NFC_TVALID, NFC_TDATA, XOFF_STATE} !== {1'b1, 16'h0000, 1'b0})
        $display("FAIL xon_request cyc=%0d got nv=%b nd=%h xs=%b required nv=1 nd=0000 xs=0",
                 i, NFC_TVALID, NFC_TDATA, XOFF_STATE);
      else npass++;
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 0, 1, i == 0);
      ntotal++;
      if ({NFC_TVALID, XOFF_STATE} !== {1'b0, 1'b0})
        $display("FAIL xon_idle cyc=%0d got nv=%b xs=%b required nv=0 xs=0", i, NFC_TVALID, XOFF_STATE);
      else npass++;
    end
  endtask

  task automatic test_refresh();
    do_reset();
    for (int i = 0; i < 13; i++) step(0, 1, {$urandom, $urandom}, 0, 1, 0);
    for (int i = 0; i < 28; i++) begin
      step(0, 0, '0, 0, 1, 1);
      ntotal++;
      if ({NFC_TVALID, XOFF_STATE, LEVEL} !== {(i % 9) == 0, 1'b1, 5'd12} ||
          (NFC_TVALID === 1'b1 && NFC_TDATA !== 16'h00FF))
        $display("FAIL refresh cyc=%0d got nv=%b nd=%h xs=%b lvl=%0d required nv=%b nd=00ff xs=1 lvl=12",
                 i, NFC_TVALID, NFC_TDATA, XOFF_STATE, LEVEL, (i % 9) == 0);
      else npass++;
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] w[19];
    int k;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      w[i] = {$urandom, $urandom};
      step(0, 1, w[i], i[0], 1, 0);
      ntotal++;
      if ({OVERFLOW, LEVEL} !== {i >= 17, m_lvl})
        $display("FAIL overflow_fill cyc=%0d got ovf=%b lvl=%0d required ovf=%b lvl=%0d",
                 i, OVERFLOW, LEVEL, i >= 17, m_lvl);
      else npass++;
    end
    ntotal++;
    if (LEVEL !== 5'd16) $display("FAIL overflow_full got lvl=%0d required 16", LEVEL);
    else npass++;
    step(0, 1, {$urandom, $urandom}, 0, 0, 0);
    ntotal++;
    if ({LEVEL, OVERFLOW, Q} !== {5'd15, 1'b1, w[1]})
      $display("FAIL overflow_read_full got lvl=%0d ovf=%b q=%h required lvl=15 ovf=1 q=%h", LEVEL, OVERFLOW, Q, w[1]);
    else npass++;
    k = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, '0, 0, 0, 0);
      if (k < 16) begin
        k++;
        ntotal++;
        if ({Q_VALID, Q} !== {1'b1, w[k]})
          $display("FAIL overflow_drain idx=%0d got v=%b q=%h required v=1 q=%h", k, Q_VALID, Q, w[k]);
        else npass++;
      end
      ntotal++;
      if ({Q_VALID, Q_LAST, Q, LEVEL, OVERFLOW} !== {m_valid, m_last, m_q, m_lvl, m_ovf})
        $display("FAIL overflow_dp cyc=%0d got v=%b l=%b q=%h lvl=%0d ovf=%b required v=%b l=%b q=%h lvl=%0d ovf=%b",
                 i, Q_VALID, Q_LAST, Q, LEVEL, OVERFLOW, m_valid, m_last, m_q, m_lvl, m_ovf);
      else npass++;
    end
    ntotal++;
    if ({OVERFLOW, LEVEL, Q_VALID} !== {1'b1, 5'd0, 1'b0})
      $display("FAIL overflow_sticky got ovf=%b lvl=%0d v=%b required ovf=1 lvl=0 v=0", OVERFLOW, LEVEL, Q_VALID);
    else npass++;
    do_reset();
    ntotal++;
    if (OVERFLOW !== 1'b0) $display("FAIL overflow_clear got ovf=%b required 0", OVERFLOW);
    else npass++;
  endtask

  task automatic test_random_traffic();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i < 340)
        step(0, ($urandom % 4) != 0, {$urandom, $urandom}, $urandom_range(0, 1),
             ($urandom % 3) == 0, $urandom_range(0, 1));
      else
        step(0, 0, '0, 0, 0, 1);
      ntotal++;
      if ({Q_VALID, Q_LAST, Q, LEVEL, OVERFLOW} !== {m_valid, m_last, m_q, m_lvl, m_ovf})
        $display("FAIL random_dp cyc=%0d got v=%b l=%b q=%h lvl=%0d ovf=%b required v=%b l=%b q=%h lvl=%0d ovf=%b",
                 i, Q_VALID, Q_LAST, Q, LEVEL, OVERFLOW, m_valid, m_last, m_q, m_lvl, m_ovf);
      else npass++;
    end
  endtask

  initial begin
    RST = 1'b1; RX_TVALID = 1'b0; RX_TDATA = '0; RX_TLAST = 1'b0;
    Q_BP = 1'b0; NFC_TREADY = 1'b0;
    test_reset();
    test_passthrough();
    test_backpressure();
    test_xoff_xon();
    test_refresh();
    test_overflow();
    test_random_traffic();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
